// File: rtl/serv_mdu_pkg.sv
// Shared encodings for the serv_mdu iterative multiply/divide unit.
package serv_mdu_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam int ITERS = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/serv_mdu_sign.sv
// Combinational conditional negate; used both as absolute value and as result sign fixup.
module serv_mdu_sign #(
   parameter int W = 32
) (
   input  logic [W-1:0] a_i,
   input  logic         neg_i,
   output logic [W-1:0] y_o
);

   assign y_o = neg_i ? (~a_i + {{(W-1){1'b0}}, 1'b1}) : a_i;

endmodule

// File: rtl/serv_mdu.sv
// Iterative RISC-V M-extension unit: one shift-add / restoring-subtract step per cycle.
// Macro SERV_MDU_DIV_EN compiles in the divide/remainder datapath.
module serv_mdu
   import serv_mdu_pkg::*;
(
   input  logic        clk,
   input  logic        i_rst,
   input  logic        i_valid,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_rs1,
   input  logic [31:0] i_rs2,
   output logic [31:0] o_rd,
   output logic        o_ready
);

   state_e      state_q;
   logic [4:0]  cnt_q;
   logic [63:0] acc_q, acc_d;
   logic [31:0] b_q;
   logic [2:0]  op_q;
   logic        neg1_q, neg2_q;
   logic [31:0] rd_q, rd_d;
   logic        ready_q;

   logic        sgn1, sgn2;
   logic [31:0] mag1, mag2;

   assign sgn1 = (i_funct3 == F3_MULH) || (i_funct3 == F3_MULHSU) ||
                 (i_funct3 == F3_DIV)  || (i_funct3 == F3_REM);
   assign sgn2 = (i_funct3 == F3_MULH) || (i_funct3 == F3_DIV) || (i_funct3 == F3_REM);

   serv_mdu_sign #(.W(32)) u_abs1 (.a_i(i_rs1), .neg_i(sgn1 & i_rs1[31]), .y_o(mag1));
   serv_mdu_sign #(.W(32)) u_abs2 (.a_i(i_rs2), .neg_i(sgn2 & i_rs2[31]), .y_o(mag2));

   // acc holds {partial_hi, multiplier} for multiply, {remainder, dividend/quotient} for divide
   logic [32:0] mul_sum;
   assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);

`ifdef SERV_MDU_DIV_EN
   logic        dz_q;
   logic [64:0] div_sh;
   logic [33:0] div_diff;
   assign div_sh   = {acc_q, 1'b0};
   assign div_diff = {1'b0, div_sh[64:32]} - {2'b00, b_q};

   always_comb begin
      acc_d = {mul_sum, acc_q[31:1]};
      if (op_q[2]) begin
         if (div_diff[33]) acc_d = div_sh[63:0];
         else              acc_d = {div_diff[31:0], div_sh[31:1], 1'b1};
      end
   end
`else
   assign acc_d = {mul_sum, acc_q[31:1]};
`endif

   logic        is_div, is_rem;
   logic [63:0] fix_in, fix_out;
   logic        fix_neg;

   assign is_div  = op_q[2];
   assign is_rem  = op_q[2] & op_q[1];
   assign fix_in  = is_div ? {32'd0, (is_rem ? acc_q[63:32] : acc_q[31:0])} : acc_q;
   assign fix_neg = is_rem ? neg1_q : (neg1_q ^ neg2_q);

   serv_mdu_sign #(.W(64)) u_fix (.a_i(fix_in), .neg_i(fix_neg), .y_o(fix_out));

   always_comb begin
      rd_d = (op_q == F3_MUL) ? fix_out[31:0] : fix_out[63:32];
      if (is_div) begin
`ifdef SERV_MDU_DIV_EN
         // REM by zero already yields the dividend; only the quotient needs overriding
         rd_d = (dz_q && !is_rem) ? 32'hFFFF_FFFF : fix_out[31:0];
`else
         rd_d = 32'd0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         acc_q   <= 64'd0;
         b_q     <= 32'd0;
         op_q    <= 3'd0;
         neg1_q  <= 1'b0;
         neg2_q  <= 1'b0;
         rd_q    <= 32'd0;
         ready_q <= 1'b0;
`ifdef SERV_MDU_DIV_EN
         dz_q    <= 1'b0;
`endif
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            IDLE: if (i_valid) begin
               op_q   <= i_funct3;
               acc_q  <= {32'd0, mag1};
               b_q    <= mag2;
               neg1_q <= sgn1 & i_rs1[31];
               neg2_q <= sgn2 & i_rs2[31];
               cnt_q  <= 5'd0;
`ifdef SERV_MDU_DIV_EN
               dz_q    <= (i_rs2 == 32'd0);
               state_q <= CALC;
`else
               state_q <= i_funct3[2] ? FIX : CALC;
`endif
            end
            CALC: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'(ITERS - 1)) state_q <= FIX;
            end
            FIX: begin
               rd_q    <= rd_d;
               ready_q <= 1'b1;
               state_q <= DONE;
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_rd    = rd_q;
   // a reset landing on the DONE cycle suppresses the completion pulse
   assign o_ready = ready_q & ~i_rst;

endmodule
